multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control
Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 OP  input  6  opcode from the instruction register, bits [31:26].
REQ-005 Funct  input  6  function field from the instruction register, bits [5:0]; used only to detect jr.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 MemReady  input  1  memory completion handshake; the access finishes in the cycle it is 1.
REQ-008 PCEn  output  1  PC load enable; branch condition already folded in.
REQ-009 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 MemRead  output  1  memory read request.
REQ-011 MemWrite  output  1  memory write strobe.
REQ-012 IRWrite  output  1  instruction register load.
REQ-013 MemtoReg  output  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-014 RegDst  output  2  write-register select: 00 = rt, 01 = rd, 10 = $31.
REQ-015 RegWrite  output  1  register file write enable.
REQ-016 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-017 ALUSrcB  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
REQ-018 ALUOp  output  3  ALU control code: ADD = 000, SUB = 001, ORI = 010, ANDI = 011, LUI = 100, RTYPE = 111.
REQ-019 PCSource  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
REQ-020 State  output  4  current state code, for debug and the bench.
Function
REQ-021 The block SHALL be a Moore FSM; only PCEn, IRWrite and the memory-access advance depend combinationally on Zero and MemReady.
REQ-022 States and codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, JR=12, JAL=13; codes 14 and 15 SHALL go to FETCH.
REQ-023 FETCH SHALL drive: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
REQ-024 FETCH SHALL hold until MemReady=1; in that cycle IRWrite=1, PCEn=1 and the next state is DECODE.
REQ-025 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut).
REQ-026 DECODE dispatch SHALL be:
- lw 0x23 or sw 0x2B -> MEMADR
- OP=0 with Funct=0x08 -> JR; any other OP=0 -> RTEXEC
- beq 0x04 or bne 0x05 -> BRANCH
- addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F -> IEXEC
- j 0x02 -> JUMP; jal 0x03 -> JAL
- any other opcode -> FETCH, with no write enables asserted.
REQ-027 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, then go to MEMRD for lw or MEMWR for sw.
REQ-028 MEMRD and MEMWR SHALL drive IorD=1 with MemRead=1 or MemWrite=1, and hold until MemReady=1.
REQ-029 MEMRD SHALL then go to MEMWB; MEMWR SHALL then go to FETCH.
REQ-030 MEMWB SHALL drive RegWrite=1, RegDst=00, MemtoReg=01, then go to FETCH.
REQ-031 RTEXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE.
REQ-032 RTWB SHALL drive RegWrite=1, RegDst=01, MemtoReg=00.
REQ-033 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp ADD/ANDI/ORI/LUI by opcode.
REQ-034 IWB SHALL drive RegWrite=1, RegDst=00, MemtoReg=00.
REQ-035 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, with PCEn=(beq & Zero) | (bne & ~Zero).
REQ-036 JUMP SHALL drive PCSource=10, PCEn=1; JR SHALL drive PCSource=11, PCEn=1.
REQ-037 JAL SHALL drive RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10, PCEn=1 in the same cycle (the PC already holds PC+4).
REQ-038 RTEXEC->RTWB, IEXEC->IWB; RTWB, IWB, BRANCH, JUMP, JR and JAL SHALL go to FETCH.
REQ-039 Every output not listed for a state SHALL be 0.
REQ-040 With MemReady held at 1, instruction latency SHALL be: lw 5 cycles; sw, R-type and I-type 4; branch, j, jr and jal 3.
Reset
REQ-041 While reset=1 at a rising edge, the state SHALL become FETCH.
REQ-042 During any cycle with reset=1, PCEn, IRWrite, RegWrite, MemWrite and MemRead SHALL be 0; this also applies mid-operation, e.g. inside MEMWR.
Structure
REQ-043 Package mc_pkg SHALL hold the state enum, ALUOp codes, opcode/funct constants and mux select codes.
REQ-044 The combinational state-to-control-word decode SHALL be one sub-module, multicycle_ctrl_decode; the state register and next-state logic SHALL stay in multicycle_control.
Verification
REQ-045 add (OP=0, Funct=0x20), MemReady=1: States 0,1,6,7,0; RegWrite=1 with RegDst=01 only in state 7.
REQ-046 lw with MemReady low for 3 cycles in MEMRD: MEMRD lasts 4 cycles, with MemRead=1, IorD=1 throughout; then MEMWB with MemtoReg=01.
REQ-047 beq with Zero=0 -> PCEn=0 in BRANCH; bne with Zero=0 -> PCEn=1 with PCSource=01.
REQ-048 jal: States 0,1,13; RegDst=10, MemtoReg=10, PCEn=1 in state 13; OP=0x3F -> States 0,1,0 with no write strobes.
REQ-049 Reset asserted during MEMWR: MemWrite=0 in the reset cycle and State=0 the next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-style control unit:
// state codes, ALU codes, opcodes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_JAL    = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ORI   = 3'b010;
  localparam logic [2:0] ALU_ANDI  = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic       ADDR_PC     = 1'b0;
  localparam logic       ADDR_ALUOUT = 1'b1;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_REG = 1'b1;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef struct packed {
    logic       pc_en;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] code;
    code = ALU_ADD;
    if (op == OP_ANDI) code = ALU_ANDI;
    if (op == OP_ORI)  code = ALU_ORI;
    if (op == OP_LUI)  code = ALU_LUI;
    return code;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Per-state control word; only PCEn and IRWrite look at
// Zero / MemReady, everything else follows the state alone.
module multicycle_ctrl_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // state to control word, unlisted fields stay zero
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ior_d     = ADDR_PC;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.ior_d    = ADDR_ALUOUT;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RT;
        ctrl.mem_to_reg = WD_MDR;
      end
      S_MEMWR: begin
        ctrl.ior_d     = ADDR_ALUOUT;
        ctrl.mem_write = 1'b1;
      end
      S_RTEXEC: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_RTWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RD;
        ctrl.mem_to_reg = WD_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_en     = ((op == OP_BEQ) & zero)
                       | ((op == OP_BNE) & ~zero);
      end
      S_IEXEC: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(op);
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RT;
        ctrl.mem_to_reg = WD_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      S_JR: begin
        ctrl.pc_source = PCSRC_REG;
        ctrl.pc_en     = 1'b1;
      end
      S_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RA;
        ctrl.mem_to_reg = WD_PC;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_en      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: state register, next-state logic,
// and reset gating of the write/request strobes.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // next-state selection, including opcode dispatch
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:
            state_d = (Funct == FUNCT_JR) ? S_JR : S_RTEXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:
            state_d = S_IEXEC;
          OP_J:   state_d = S_JUMP;
          OP_JAL: state_d = S_JAL;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
      S_RTEXEC: state_d = S_RTWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  multicycle_ctrl_decode u_decode (
    .state     (state_q),
    .op        (OP),
    .zero      (Zero),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  assign PCEn     = ctrl.pc_en & ~reset;
  assign IRWrite  = ctrl.ir_write & ~reset;
  assign RegWrite = ctrl.reg_write & ~reset;
  assign MemWrite = ctrl.mem_write & ~reset;
  assign MemRead  = ctrl.mem_read & ~reset;
  assign IorD     = ctrl.ior_d;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegDst   = ctrl.reg_dst;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign PCSource = ctrl.pc_source;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction walks,
// memory wait states, branch conditions and reset mid-op.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk      (clk),
    .reset    (reset),
    .OP       (OP),
    .Funct    (Funct),
    .Zero     (Zero),
    .MemReady (MemReady),
    .PCEn     (PCEn),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .MemtoReg (MemtoReg),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSource (PCSource),
    .State    (State)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; OP = 6'h00; Funct = 6'h00;
    Zero = 1'b0; MemReady = 1'b1;
    tick();
    tick();
    #2;
    checks++;
    if (State !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", State);
    end
    checks++;
    if ({MemRead, IRWrite, PCEn} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000",
               {MemRead, IRWrite, PCEn});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({MemRead, IRWrite, PCEn} !== 3'b111) begin
      errors++;
      $display("FAIL fetch_ready: got %b want 111",
               {MemRead, IRWrite, PCEn});
    end
    checks++;
    if ({IorD, ALUSrcA, ALUSrcB, ALUOp} !== 7'b0001000) begin
      errors++;
      $display("FAIL fetch_mux: got %b want 0001000",
               {IorD, ALUSrcA, ALUSrcB, ALUOp});
    end
    MemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      #2;
      checks++;
      if ({State, MemRead, IRWrite, PCEn} !== 7'b0000100) begin
        errors++;
        $display("FAIL fetch_hold: got %b want 0000100",
                 {State, MemRead, IRWrite, PCEn});
      end
    end
    tick();
  endtask

  task automatic test_rtype_add();
    logic [3:0] st [4];
    st = '{4'd0, 4'd1, 4'd6, 4'd7};
    OP = 6'h00; Funct = 6'h20; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (State !== st[i]) begin
        errors++;
        $display("FAIL add_state[%0d]: got %0d want %0d",
                 i, State, st[i]);
      end
      checks++;
      if (RegWrite !== (st[i] == 4'd7)) begin
        errors++;
        $display("FAIL add_regwrite[%0d]: got %b", i, RegWrite);
      end
      if (st[i] == 4'd6) begin
        checks++;
        if ({ALUSrcA, ALUSrcB, ALUOp} !== 6'b100111) begin
          errors++;
          $display("FAIL add_exec: got %b want 100111",
                   {ALUSrcA, ALUSrcB, ALUOp});
        end
      end
      if (st[i] == 4'd7) begin
        checks++;
        if ({RegDst, MemtoReg} !== 4'b0100) begin
          errors++;
          $display("FAIL add_wb: got %b want 0100",
                   {RegDst, MemtoReg});
        end
      end
      tick();
    end
    checks++;
    if (State !== 4'd0) begin
      errors++;
      $display("FAIL add_end: got %0d want 0", State);
    end
  endtask

  task automatic test_itype_ori();
    logic [3:0] st [4];
    st = '{4'd0, 4'd1, 4'd9, 4'd10};
    OP = 6'h0D; Funct = 6'h00; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (State !== st[i]) begin
        errors++;
        $display("FAIL ori_state[%0d]: got %0d want %0d",
                 i, State, st[i]);
      end
      if (st[i] == 4'd9) begin
        checks++;
        if ({ALUSrcA, ALUSrcB, ALUOp} !== 6'b110010) begin
          errors++;
          $display("FAIL ori_exec: got %b want 110010",
                   {ALUSrcA, ALUSrcB, ALUOp});
        end
      end
      if (st[i] == 4'd10) begin
        checks++;
        if ({RegWrite, RegDst, MemtoReg} !== 5'b10000) begin
          errors++;
          $display("FAIL ori_wb: got %b want 10000",
                   {RegWrite, RegDst, MemtoReg});
        end
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] st [8];
    logic       rdy [8];
    st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    OP = 6'h23; Funct = 6'h00;
    for (int i = 0; i < 8; i++) begin
      MemReady = rdy[i];
      #2;
      checks++;
      if (State !== st[i]) begin
        errors++;
        $display("FAIL lw_state[%0d]: got %0d want %0d",
                 i, State, st[i]);
      end
      if (st[i] == 4'd2) begin
        checks++;
        if ({ALUSrcA, ALUSrcB} !== 3'b110) begin
          errors++;
          $display("FAIL lw_adr: got %b want 110",
                   {ALUSrcA, ALUSrcB});
        end
      end
      if (st[i] == 4'd3) begin
        checks++;
        if ({MemRead, IorD, MemWrite} !== 3'b110) begin
          errors++;
          $display("FAIL lw_memrd[%0d]: got %b want 110",
                   i, {MemRead, IorD, MemWrite});
        end
      end
      if (st[i] == 4'd4) begin
        checks++;
        if ({RegWrite, RegDst, MemtoReg} !== 5'b10001) begin
          errors++;
          $display("FAIL lw_wb: got %b want 10001",
                   {RegWrite, RegDst, MemtoReg});
        end
      end
      tick();
    end
    MemReady = 1'b1;
  endtask

  task automatic test_branch();
    logic [5:0] ops [3];
    logic       zs  [3];
    logic       pe  [3];
    ops = '{6'h04, 6'h05, 6'h04};
    zs  = '{1'b0, 1'b0, 1'b1};
    pe  = '{1'b0, 1'b1, 1'b1};
    MemReady = 1'b1; Funct = 6'h00;
    for (int k = 0; k < 3; k++) begin
      OP = ops[k]; Zero = zs[k];
      tick();
      tick();
      #2;
      checks++;
      if (State !== 4'd8) begin
        errors++;
        $display("FAIL br_state[%0d]: got %0d want 8", k, State);
      end
      checks++;
      if (PCEn !== pe[k]) begin
        errors++;
        $display("FAIL br_pcen[%0d]: got %b want %b",
                 k, PCEn, pe[k]);
      end
      checks++;
      if ({PCSource, ALUOp, ALUSrcA} !== 6'b010011) begin
        errors++;
        $display("FAIL br_mux[%0d]: got %b want 010011",
                 k, {PCSource, ALUOp, ALUSrcA});
      end
      tick();
    end
    Zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    logic [3:0] st  [3];
    logic [1:0] ps  [3];
    ops = '{6'h03, 6'h00, 6'h02};
    fns = '{6'h00, 6'h08, 6'h00};
    st  = '{4'd13, 4'd12, 4'd11};
    ps  = '{2'b10, 2'b11, 2'b10};
    MemReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      OP = ops[k]; Funct = fns[k];
      tick();
      tick();
      #2;
      checks++;
      if (State !== st[k]) begin
        errors++;
        $display("FAIL jmp_state[%0d]: got %0d want %0d",
                 k, State, st[k]);
      end
      checks++;
      if ({PCEn, PCSource} !== {1'b1, ps[k]}) begin
        errors++;
        $display("FAIL jmp_pc[%0d]: got %b want %b",
                 k, {PCEn, PCSource}, {1'b1, ps[k]});
      end
      checks++;
      if (k == 0) begin
        if ({RegWrite, RegDst, MemtoReg} !== 5'b11010) begin
          errors++;
          $display("FAIL jal_wb: got %b want 11010",
                   {RegWrite, RegDst, MemtoReg});
        end
      end else if (RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL jmp_regwrite[%0d]: got %b want 0",
                 k, RegWrite);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    OP = 6'h3F; Funct = 6'h00; MemReady = 1'b1;
    tick();
    #2;
    checks++;
    if (State !== 4'd1) begin
      errors++;
      $display("FAIL ill_decode: got %0d want 1", State);
    end
    checks++;
    if ({RegWrite, MemWrite, PCEn, IRWrite, MemRead}
        !== 5'b00000) begin
      errors++;
      $display("FAIL ill_strobes: got %b want 00000",
               {RegWrite, MemWrite, PCEn, IRWrite, MemRead});
    end
    checks++;
    if ({ALUSrcA, ALUSrcB} !== 3'b011) begin
      errors++;
      $display("FAIL ill_target: got %b want 011",
               {ALUSrcA, ALUSrcB});
    end
    tick();
    #1;
    checks++;
    if (State !== 4'd0) begin
      errors++;
      $display("FAIL ill_back: got %0d want 0", State);
    end
  endtask

  task automatic test_reset_in_memwr();
    OP = 6'h2B; Funct = 6'h00; MemReady = 1'b1;
    tick();
    tick();
    tick();
    MemReady = 1'b0;
    #2;
    checks++;
    if ({State, MemWrite, IorD, MemRead} !== 7'b0101110) begin
      errors++;
      $display("FAIL sw_memwr: got %b want 0101110",
               {State, MemWrite, IorD, MemRead});
    end
    tick();
    reset = 1'b1;
    #2;
    checks++;
    if ({State, MemWrite} !== 5'b01010) begin
      errors++;
      $display("FAIL rst_memwr: got %b want 01010",
               {State, MemWrite});
    end
    tick();
    #1;
    checks++;
    if (State !== 4'd0) begin
      errors++;
      $display("FAIL rst_after: got %0d want 0", State);
    end
    reset = 1'b0;
    MemReady = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_itype_ori();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_illegal();
    test_reset_in_memwr();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
